// File: rtl/instr_encode_issue.sv
// Encodes symbolic operation requests into 16-bit instruction words and queues them for decode.
// Optional ISSUE_STATS_EN adds saturating issue/reject counters.
module instr_encode_issue #(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_kind,
    input  logic [2:0]       req_alu_op,
    input  logic [2:0]       req_rs,
    input  logic [2:0]       req_rt,
    input  logic [2:0]       req_rd,
    input  logic [11:0]      req_imm,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [15:0]      instr,
    output logic             err_illegal,
    output logic [PTR_W:0]   fifo_count
`ifdef ISSUE_STATS_EN
    ,
    output logic [15:0]      issue_count,
    output logic [7:0]       reject_count
`endif
);

    typedef struct packed {
        logic [2:0]  kind;
        logic [2:0]  alu_op;
        logic [2:0]  rs;
        logic [2:0]  rt;
        logic [2:0]  rd;
        logic [11:0] imm;
    } req_t;

    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_MAX = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    req_t             req;
    logic [15:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             err_q;
    logic             full, empty, push_hs, pop, push, legal, imm_fits;
    logic [15:0]      enc;

    assign req = '{kind: req_kind, alu_op: req_alu_op, rs: req_rs, rt: req_rt,
                   rd: req_rd, imm: req_imm};

    assign full        = (count == CNT_MAX);
    assign empty       = (count == '0);
    assign req_ready   = !full && !reset;
    assign instr_valid = !empty;
    assign instr       = mem[rd_ptr];
    assign err_illegal = err_q;
    assign fifo_count  = count;

    // I-type immediates must be a sign-extended 6-bit value
    assign imm_fits = (&req.imm[11:5]) || !(|req.imm[11:5]);

    always_comb begin
        enc   = '0;
        legal = 1'b1;
        case (req.kind)
            3'd0: begin
                enc   = {4'b0000, req.rs, req.rt, req.rd, req.alu_op};
                legal = (req.alu_op != 3'b111);
            end
            3'd1: begin enc = {4'b0100, req.rs, req.rt, req.imm[5:0]}; legal = imm_fits; end
            3'd2: begin enc = {4'b1011, req.rs, req.rt, req.imm[5:0]}; legal = imm_fits; end
            3'd3: begin enc = {4'b1111, req.rs, req.rt, req.imm[5:0]}; legal = imm_fits; end
            3'd4: begin enc = {4'b1000, req.rs, req.rt, req.imm[5:0]}; legal = imm_fits; end
            3'd5: enc = {4'b0010, req.imm};
            default: legal = 1'b0;
        endcase
    end

    assign push_hs = req_valid && req_ready;
    assign push    = push_hs && legal && !flush;
    assign pop     = instr_valid && instr_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= push_hs && !legal && !flush;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_ONE;
                if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
                case ({push, pop})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: count <= count;
                endcase
            end
        end
    end

    // Storage is deliberately left uncleared by reset
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= enc;
    end

`ifdef ISSUE_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            issue_count  <= '0;
            reject_count <= '0;
        end else begin
            if (pop && issue_count != 16'hFFFF) issue_count <= issue_count + 16'd1;
            if (err_q && reject_count != 8'hFF) reject_count <= reject_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_encode_issue.sv
// Randomized bench for instr_encode_issue: a queue-based reference model checked every cycle,
// plus directed sequences with hand-computed expectations.
module tb_instr_encode_issue;
    localparam int DEPTH = 4;
    localparam int PTR_W = $clog2(DEPTH);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset, flush, req_valid, req_ready, instr_valid, instr_ready, err_illegal;
    logic [2:0]       req_kind, req_alu_op, req_rs, req_rt, req_rd;
    logic [11:0]      req_imm;
    logic [15:0]      instr;
    logic [PTR_W:0]   fifo_count;
`ifdef ISSUE_STATS_EN
    logic [15:0]      issue_count;
    logic [7:0]       reject_count;
    int               exp_issue, exp_rej;
`endif

    instr_encode_issue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_kind(req_kind), .req_alu_op(req_alu_op),
        .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_imm(req_imm),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .err_illegal(err_illegal), .fifo_count(fifo_count)
`ifdef ISSUE_STATS_EN
        , .issue_count(issue_count), .reject_count(reject_count)
`endif
    );

    int          vectors = 0, miscompares = 0;
    logic [15:0] q[$];
    bit          exp_err = 1'b0;
    bit          started = 1'b0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_legal(logic [2:0] k, logic [2:0] op, logic [11:0] imm);
        int v;
        v = $signed(imm);
        if (k > 3'd5) return 1'b0;
        if (k == 3'd0) return op != 3'd7;
        if (k <= 3'd4) return (v >= -32) && (v <= 31);
        return 1'b1;
    endfunction

    function automatic logic [15:0] encode(logic [2:0] k, op, a, b, d, logic [11:0] imm);
        logic [5:0] i6;
        i6 = imm[5:0];
        case (k)
            3'd0:    return {4'h0, a, b, d, op};
            3'd1:    return {4'h4, a, b, i6};
            3'd2:    return {4'hB, a, b, i6};
            3'd3:    return {4'hF, a, b, i6};
            3'd4:    return {4'h8, a, b, i6};
            default: return {4'h2, imm};
        endcase
    endfunction

    // Reference model: advances on each rising edge from the inputs held across it
    always @(posedge clk) begin
        bit rdy, hs, pp, lg;
        if (reset) begin
            q.delete();
            exp_err = 1'b0;
`ifdef ISSUE_STATS_EN
            exp_issue = 0;
            exp_rej   = 0;
`endif
        end else begin
            rdy = q.size() < DEPTH;
            hs  = req_valid && rdy;
            pp  = (q.size() > 0) && instr_ready;
            lg  = is_legal(req_kind, req_alu_op, req_imm);
`ifdef ISSUE_STATS_EN
            if (pp && exp_issue < 16'hFFFF) exp_issue++;
            if (exp_err && exp_rej < 8'hFF) exp_rej++;
`endif
            exp_err = hs && !lg && !flush;
            if (flush) q.delete();
            else begin
                if (pp) void'(q.pop_front());
                if (hs && lg) q.push_back(encode(req_kind, req_alu_op, req_rs, req_rt, req_rd, req_imm));
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("instr_valid", instr_valid, q.size() != 0);
            if (q.size() != 0) chk("instr", instr, q[0]);
            chk("fifo_count", fifo_count, q.size());
            chk("req_ready", req_ready, !reset && (q.size() < DEPTH));
            chk("err_illegal", err_illegal, exp_err);
`ifdef ISSUE_STATS_EN
            chk("issue_count", issue_count, exp_issue);
            chk("reject_count", reject_count, exp_rej);
`endif
        end
    end

    task automatic send(bit v, logic [2:0] k, op, a, b, d, logic [11:0] imm, bit ir, bit fl, bit rs);
        req_valid = v; req_kind = k; req_alu_op = op;
        req_rs = a; req_rt = b; req_rd = d; req_imm = imm;
        instr_ready = ir; flush = fl; reset = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(bit ir);
        send(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 12'h0, ir, 1'b0, 1'b0);
    endtask

    task automatic push_addi(bit ir);
        send(1'b1, 3'd1, 3'd0, 3'($urandom), 3'($urandom), 3'd0, 12'($urandom_range(0, 31)), ir, 1'b0, 1'b0);
    endtask

    initial begin
        send(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 12'h0, 1'b0, 1'b0, 1'b1);
        send(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 12'h0, 1'b0, 1'b0, 1'b1);
        started = 1'b1;
        chk("rst_count", fifo_count, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_err", err_illegal, 0);

        // single ALU word, then popped
        send(1'b1, 3'd0, 3'b010, 3'd1, 3'd2, 3'd3, 12'h0, 1'b1, 1'b0, 1'b0);
        chk("alu_valid", instr_valid, 1);
        chk("alu_word", instr, 16'h029A);
        idle(1'b1);
        chk("alu_drained", fifo_count, 0);

        // fill to full, fifth request stalls until a pop
        send(1'b1, 3'd2, 3'd0, 3'd0, 3'd1, 3'd0, 12'hFFF, 1'b0, 1'b0, 1'b0);
        repeat (3) push_addi(1'b0);
        chk("full_count", fifo_count, 4);
        chk("full_ready", req_ready, 0);
        chk("lw_word", instr, 16'hB07F);
        send(1'b1, 3'd1, 3'd0, 3'd5, 3'd6, 3'd0, 12'h011, 1'b0, 1'b0, 1'b0);
        chk("full_hold", fifo_count, 4);
        send(1'b1, 3'd1, 3'd0, 3'd5, 3'd6, 3'd0, 12'h011, 1'b1, 1'b0, 1'b0);
        chk("full_pop_only", fifo_count, 3);
        send(1'b1, 3'd1, 3'd0, 3'd5, 3'd6, 3'd0, 12'h011, 1'b0, 1'b0, 1'b0);
        chk("fifth_in", fifo_count, 4);
        repeat (5) idle(1'b1);
        chk("drain", fifo_count, 0);

        // illegal requests
        send(1'b1, 3'd0, 3'b111, 3'd1, 3'd1, 3'd1, 12'h0, 1'b1, 1'b0, 1'b0);
        chk("ill_alu_err", err_illegal, 1);
        send(1'b1, 3'd1, 3'd0, 3'd1, 3'd1, 3'd0, 12'h020, 1'b1, 1'b0, 1'b0);
        chk("ill_imm_err", err_illegal, 1);
        chk("ill_imm_count", fifo_count, 0);
        send(1'b1, 3'd6, 3'd0, 3'd0, 3'd0, 3'd0, 12'h0, 1'b1, 1'b0, 1'b0);
        chk("ill_kind_err", err_illegal, 1);
        idle(1'b1);
        chk("ill_err_clear", err_illegal, 0);
        chk("ill_valid", instr_valid, 0);

        // J word, then push+pop at count 2 across pointer wrap
        send(1'b1, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0, 12'hABC, 1'b0, 1'b0, 1'b0);
        chk("j_word", instr, 16'h2ABC);
        push_addi(1'b0);
        repeat (6) begin
            push_addi(1'b1);
            chk("pushpop_count", fifo_count, 2);
        end
        repeat (3) idle(1'b1);

        // flush drops a concurrent legal request without error
        repeat (3) push_addi(1'b0);
        send(1'b1, 3'd1, 3'd0, 3'd2, 3'd3, 3'd0, 12'h005, 1'b0, 1'b1, 1'b0);
        chk("flush_count", fifo_count, 0);
        chk("flush_valid", instr_valid, 0);
        chk("flush_err", err_illegal, 0);

        // reset mid-stream
        repeat (3) push_addi(1'b0);
        send(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 12'h0, 1'b0, 1'b0, 1'b1);
        chk("mrst_count", fifo_count, 0);
        chk("mrst_valid", instr_valid, 0);
        chk("mrst_err", err_illegal, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [11:0] imm;
            imm = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($signed(6'($urandom)));
            send($urandom_range(0, 2) != 0, 3'($urandom), 3'($urandom), 3'($urandom),
                 3'($urandom), 3'($urandom), imm, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 31) == 0, $urandom_range(0, 127) == 0);
        end
        idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
